sync_fifo_flags: RTL and testbench

// - Synthesisable single-clock FIFO; successor to the testbench FIFO model, used on the IEEE1355 link datapath.
// - Adds full/empty/almost flags, a fill-level output, sticky overflow/underflow errors and first-word-fall-through reads.
// - Buffers characters between the link receiver and host-side logic (depth = 2**G_ADDR_WIDTH_BITS).

---
 rtl/sync_fifo_flags.sv | 125 ++++++++++++
 tb/tb_sync_fifo_flags.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_flags.sv
// Single-clock first-word-fall-through FIFO with occupancy flags, fill level and sticky errors.
// Optional high-water-mark tracking is built only when SYNC_FIFO_HWM_EN is defined.
module sync_fifo_flags #(
  parameter int G_DATA_WIDTH_BITS = 9,
  parameter int G_ADDR_WIDTH_BITS = 6,
  parameter int G_AFULL_THRESH    = 56,
  parameter int G_AEMPTY_THRESH   = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         w_en,
  input  logic [G_DATA_WIDTH_BITS-1:0] w_data,
  input  logic                         r_en,
  output logic [G_DATA_WIDTH_BITS-1:0] r_data,
  output logic                         full,
  output logic                         empty,
  output logic                         almost_full,
  output logic                         almost_empty,
  output logic [G_ADDR_WIDTH_BITS:0]   fill_level,
  output logic                         overflow,
  output logic                         underflow,
  input  logic                         clr_err,
  output logic [G_ADDR_WIDTH_BITS:0]   hwm_level
);

  localparam int DW      = G_DATA_WIDTH_BITS;
  localparam int AW      = G_ADDR_WIDTH_BITS;
  localparam int DEPTH_C = 1 << AW;

  localparam logic [AW:0]   DEPTH_L    = (AW+1)'(DEPTH_C);
  localparam logic [AW:0]   AFULL_L    = (AW+1)'(G_AFULL_THRESH);
  localparam logic [AW:0]   AEMPTY_L   = (AW+1)'(G_AEMPTY_THRESH);
  localparam logic [AW:0]   FILL_ONE_L = (AW+1)'(32'd1);
  localparam logic [AW:0]   FILL_ZERO_L = (AW+1)'(32'd0);
  localparam logic [AW-1:0] PTR_ONE_L  = AW'(32'd1);
  localparam logic [AW-1:0] PTR_ZERO_L = AW'(32'd0);

  logic [DW-1:0] mem_r [DEPTH_C];
  logic [AW-1:0] w_ptr_r;
  logic [AW-1:0] r_ptr_r;
  logic          wr_acc_s;
  logic          rd_acc_s;
  logic          ovf_set_s;
  logic          udf_set_s;
  logic [AW:0]   fill_next_s;

  // Accept/error decode and next occupancy; a full FIFO still takes a write when a read frees a slot
  always_comb begin
    wr_acc_s    = w_en & (~full | r_en);
    rd_acc_s    = r_en & ~empty;
    ovf_set_s   = w_en & full & ~r_en;
    udf_set_s   = r_en & empty;
    fill_next_s = fill_level;
    case ({wr_acc_s, rd_acc_s})
      2'b10:   fill_next_s = fill_level + FILL_ONE_L;
      2'b01:   fill_next_s = fill_level - FILL_ONE_L;
      default: fill_next_s = fill_level;
    endcase
  end

  // Pointers, occupancy, flags and sticky errors; every flag derives from the next occupancy
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      w_ptr_r      <= PTR_ZERO_L;
      r_ptr_r      <= PTR_ZERO_L;
      fill_level   <= FILL_ZERO_L;
      empty        <= 1'b1;
      full         <= 1'b0;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      if (wr_acc_s) begin
        w_ptr_r <= w_ptr_r + PTR_ONE_L;
      end
      if (rd_acc_s) begin
        r_ptr_r <= r_ptr_r + PTR_ONE_L;
      end
      fill_level   <= fill_next_s;
      empty        <= (fill_next_s == FILL_ZERO_L);
      full         <= (fill_next_s == DEPTH_L);
      almost_full  <= (fill_next_s >= AFULL_L);
      almost_empty <= (fill_next_s <= AEMPTY_L);
      overflow     <= ovf_set_s | (overflow & ~clr_err);
      underflow    <= udf_set_s | (underflow & ~clr_err);
    end
  end

  // Storage array, deliberately left unreset so it can map onto RAM
  always_ff @(posedge clk) begin
    if (rst_n && wr_acc_s) begin
      mem_r[w_ptr_r] <= w_data;
    end
  end

  // Fall-through head word, forced to zero while nothing is stored
  always_comb begin
    if (empty) begin
      r_data = {DW{1'b0}};
    end else begin
      r_data = mem_r[r_ptr_r];
    end
  end

`ifdef SYNC_FIFO_HWM_EN
  logic [AW:0] hwm_r;

  // High-water mark; clr_err restarts tracking from the current occupancy
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hwm_r <= FILL_ZERO_L;
    end else if (clr_err) begin
      hwm_r <= fill_next_s;
    end else if (fill_next_s > hwm_r) begin
      hwm_r <= fill_next_s;
    end
  end

  assign hwm_level = hwm_r;
`else
  assign hwm_level = {(AW+1){1'b0}};
`endif

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Randomized and directed bench for sync_fifo_flags against a queue-based occupancy model.
// Honours SYNC_FIFO_HWM_EN for the expected high-water mark.
module tb_sync_fifo_flags;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       w_en = 1'b0;
  logic [8:0] w_data = 9'd0;
  logic       r_en = 1'b0;
  logic       clr_err = 1'b0;
  logic [8:0] r_data;
  logic       full, empty, almost_full, almost_empty, overflow, underflow;
  logic [6:0] fill_level, hwm_level;

  int total = 0;
  int bad = 0;

  sync_fifo_flags dut (
    .clk(clk), .rst_n(rst_n), .w_en(w_en), .w_data(w_data), .r_en(r_en),
    .r_data(r_data), .full(full), .empty(empty), .almost_full(almost_full),
    .almost_empty(almost_empty), .fill_level(fill_level), .overflow(overflow),
    .underflow(underflow), .clr_err(clr_err), .hwm_level(hwm_level)
  );

  always #5 clk = ~clk;

  // Behavioural model: a queue of stored words plus sticky bits
  logic [8:0] m_q[$];
  bit         m_ovf = 1'b0;
  bit         m_udf = 1'b0;
  int         m_hwm = 0;
  bit         chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_step();
    bit was_full, was_empty, wacc, racc;
    if (!rst_n) begin
      m_q.delete();
      m_ovf  = 1'b0;
      m_udf  = 1'b0;
      m_hwm  = 0;
      chk_en = 1'b1;
    end else begin
      was_full  = (m_q.size() == 64);
      was_empty = (m_q.size() == 0);
      wacc = w_en && (!was_full || r_en);
      racc = r_en && !was_empty;
      if (racc) void'(m_q.pop_front());
      if (wacc) m_q.push_back(w_data);
      m_ovf = (w_en && was_full && !r_en) || (m_ovf && !clr_err);
      m_udf = (r_en && was_empty) || (m_udf && !clr_err);
      if (clr_err) m_hwm = m_q.size();
      else if (m_q.size() > m_hwm) m_hwm = m_q.size();
    end
  endtask

  // Single compare process: advance the model on each edge, then check every output
  always @(posedge clk) begin
    int n;
    model_step();
    #1;
    if (chk_en) begin
      n = m_q.size();
      chk("r_data", 32'(r_data), (n == 0) ? 32'd0 : 32'(m_q[0]));
      chk("fill_level", 32'(fill_level), 32'(n));
      chk("empty", 32'(empty), 32'(n == 0));
      chk("full", 32'(full), 32'(n == 64));
      chk("almost_full", 32'(almost_full), 32'(n >= 56));
      chk("almost_empty", 32'(almost_empty), 32'(n <= 8));
      chk("overflow", 32'(overflow), 32'(m_ovf));
      chk("underflow", 32'(underflow), 32'(m_udf));
`ifdef SYNC_FIFO_HWM_EN
      chk("hwm_level", 32'(hwm_level), 32'(m_hwm));
`else
      chk("hwm_level", 32'(hwm_level), 32'd0);
`endif
    end
  end

  task automatic step(input logic w, input logic [8:0] d, input logic r, input logic c);
    @(negedge clk);
    w_en = w; w_data = d; r_en = r; clr_err = c;
    @(posedge clk);
    #2;
  endtask

  initial begin
    int wp, rp;
    // Reset then idle
    rst_n = 1'b0;
    step(1'b0, 9'd0, 1'b0, 1'b0);
    step(1'b0, 9'd0, 1'b0, 1'b0);
    rst_n = 1'b1;
    step(1'b0, 9'd0, 1'b0, 1'b0);
    chk("lit_rst_empty", 32'(empty), 32'd1);
    chk("lit_rst_aempty", 32'(almost_empty), 32'd1);
    chk("lit_rst_full", 32'(full), 32'd0);
    chk("lit_rst_fill", 32'(fill_level), 32'd0);
    chk("lit_rst_rdata", 32'(r_data), 32'd0);
    chk("lit_rst_err", 32'({overflow, underflow}), 32'd0);

    // Fill with 0x000..0x03F, watch almost_full threshold, then overflow
    for (int i = 0; i < 64; i++) begin
      step(1'b1, 9'(i), 1'b0, 1'b0);
      chk("lit_fill_afull", 32'(almost_full), 32'(i + 1 >= 56));
    end
    chk("lit_full", 32'(full), 32'd1);
    chk("lit_full_level", 32'(fill_level), 32'd64);
    step(1'b1, 9'h1FF, 1'b0, 1'b0);
    chk("lit_ovf", 32'(overflow), 32'd1);
    chk("lit_ovf_level", 32'(fill_level), 32'd64);

    // Drain in order
    for (int i = 0; i < 64; i++) begin
      chk("lit_drain_data", 32'(r_data), 32'(i));
      step(1'b0, 9'd0, 1'b1, 1'b0);
    end
    chk("lit_drain_empty", 32'(empty), 32'd1);

    // Underflow, clear, and clear coincident with a fresh underflow
    step(1'b0, 9'd0, 1'b1, 1'b0);
    chk("lit_udf", 32'(underflow), 32'd1);
    chk("lit_udf_level", 32'(fill_level), 32'd0);
    step(1'b0, 9'd0, 1'b0, 1'b1);
    chk("lit_udf_clr", 32'(underflow), 32'd0);
    chk("lit_ovf_clr", 32'(overflow), 32'd0);
    step(1'b0, 9'd0, 1'b1, 1'b1);
    chk("lit_udf_prio", 32'(underflow), 32'd1);
    step(1'b0, 9'd0, 1'b0, 1'b1);

    // Full with simultaneous read/write across pointer wrap
    for (int i = 0; i < 64; i++) step(1'b1, 9'(i), 1'b0, 1'b0);
    for (int j = 0; j < 100; j++) begin
      chk("lit_rw_data", 32'(r_data), 32'(j));
      step(1'b1, 9'(64 + j), 1'b1, 1'b0);
      chk("lit_rw_full", 32'({full, overflow}), 32'd2);
    end
    for (int i = 0; i < 64; i++) begin
      chk("lit_rw_tail", 32'(r_data), 32'(100 + i));
      step(1'b0, 9'd0, 1'b1, 1'b0);
    end

    // Simultaneous read/write on empty
    step(1'b1, 9'h155, 1'b1, 1'b0);
    chk("lit_ew_udf", 32'(underflow), 32'd1);
    chk("lit_ew_data", 32'(r_data), 32'h155);
    chk("lit_ew_level", 32'(fill_level), 32'd1);

    // Reset mid-operation with high-water mark observation
    rst_n = 1'b0;
    step(1'b0, 9'd0, 1'b0, 1'b0);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) step(1'b1, 9'(i + 9'h0A0), 1'b0, 1'b0);
    chk("lit_w10_level", 32'(fill_level), 32'd10);
`ifdef SYNC_FIFO_HWM_EN
    chk("lit_hwm10", 32'(hwm_level), 32'd10);
`else
    chk("lit_hwm10", 32'(hwm_level), 32'd0);
`endif
    rst_n = 1'b0;
    step(1'b0, 9'd0, 1'b0, 1'b0);
    rst_n = 1'b1;
    chk("lit_mid_rst_empty", 32'(empty), 32'd1);
    chk("lit_mid_rst_level", 32'(fill_level), 32'd0);
    chk("lit_mid_rst_hwm", 32'(hwm_level), 32'd0);

    // Randomized phases biased toward filling, draining and balance
    for (int ph = 0; ph < 6; ph++) begin
      wp = (ph % 3 == 0) ? 85 : (ph % 3 == 1) ? 20 : 55;
      rp = (ph % 3 == 0) ? 25 : (ph % 3 == 1) ? 80 : 50;
      for (int k = 0; k < 400; k++) begin
        rst_n = ($urandom_range(0, 299) != 0);
        step($urandom_range(0, 99) < wp, 9'($urandom), $urandom_range(0, 99) < rp,
             $urandom_range(0, 15) == 0);
      end
    end
    rst_n = 1'b1;
    step(1'b0, 9'd0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
